dual_port_ram: RTL and testbench
================================

Name: dual_port_ram

Overview:
Simple dual-port synchronous RAM: one write port and one independent read port, sharing a single clock. Used as a small register-file / scratch buffer between producer and consumer logic in the same clock domain. The read data output is tri-stated when the read port is not enabled, so it can sit on a shared read bus.

Parameters:
ADDR_WIDTH, 5, address width for both ports; depth = 2**ADDR_WIDTH words (32 by default).
DATA_WIDTH, 8, word width in bits.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
we  input  1  write enable.
WAdr  input  ADDR_WIDTH  write address.
write  input  DATA_WIDTH  write data.
re  input  1  read enable; also enables the read output driver.
RAdr  input  ADDR_WIDTH  read address.
read  output  DATA_WIDTH  read data; high-impedance when re=0.
rd_parity_err  output  1  parity error flag for the current read word; constant 0 unless DUAL_PORT_RAM_PARITY_EN is defined.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge): all memory words cleared to 0; internal read register cleared to 0; rd_parity_err register cleared to 0. Writes are ignored in any cycle where rst=1. Reset has priority over we/re.
- Write: at a rising edge with rst=0 and we=1, mem[WAdr] <= write. When we=0, memory is unchanged regardless of WAdr/write.
- Read: at a rising edge with rst=0 and re=1, the read register <= mem[RAdr]. Latency is one clock: the address is sampled at edge N and the data appears after edge N.
- When re=0, the read register holds its value.
- Output drive is combinational on re:
  - read = read register when re=1.
  - read = all-Z when re=0, immediately and without waiting for a clock edge.
- Collision (we=1, re=1, WAdr==RAdr at the same edge): write-first. The read register captures the new write data, and memory is updated with that same data.
- Different addresses at the same edge: both operations complete independently.
- All 2**ADDR_WIDTH addresses are valid; no out-of-range case exists.
- X/Z on we or re is not supported. Inputs other than we, re and rst are don't-care when their enable is low.

Optional Feature:
Macro DUAL_PORT_RAM_PARITY_EN.
- Defined:
  - Each word is stored with one extra even-parity bit, computed from write at write time; reset clears it to 0, which is consistent with all-zero data.
  - On each read-register update, parity is recomputed over the stored data. rd_parity_err is registered alongside the read data and is 1 when it mismatches the stored bit.
  - On a collision bypass, parity is taken from write, so rd_parity_err=0.
  - rd_parity_err is not tri-stated.
- Not defined: no parity storage; rd_parity_err tied to 0.
- Port list is identical in both builds.

Test Plan:
1. Reset then read: rst=1 for one edge, then re=1 with RAdr=0x00 and RAdr=0x1F -> read=0x00 one cycle after each address.
2. Concurrent write/read, different addresses: we=1, re=1, write 0x01 to WAdr=0; next cycle write 0x02 to WAdr=1 with RAdr=0 -> read=0x01 after that edge; then RAdr=1 -> read=0x02.
3. Read enable: re=0 -> read=Z immediately; re=1 again -> previously held value (0x02) reappears with no clock edge needed.
4. Write enable: we=0, WAdr=0, write=0x03, re=1, RAdr=0 -> read=0x01 (write blocked).
5. Overwrite and collision:
   - we=1, write 0x0F to addr 0, then RAdr=0 -> read=0x0F.
   - Same edge WAdr=1, RAdr=1, write=0x0C -> read=0x0C after that edge, and a later read of addr 1 returns 0x0C.
6. Parity (DUAL_PORT_RAM_PARITY_EN defined): write 0xA5 to addr 3, force the stored parity bit inverted via hierarchical deposit, read addr 3 -> read=0xA5, rd_parity_err=1; without the macro -> rd_parity_err=0 always.

Source files
------------

// File: rtl/dual_port_ram_if.sv
// Request-side bus of the dual-port RAM: write port, read port controls and parity flag.
interface dual_port_ram_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] WAdr;
  logic [DATA_WIDTH-1:0] write;
  logic                  re;
  logic [ADDR_WIDTH-1:0] RAdr;
  logic                  rd_parity_err;

  modport master (
    output we, WAdr, write, re, RAdr,
    input  rd_parity_err
  );

  modport slave (
    input  we, WAdr, write, re, RAdr,
    output rd_parity_err
  );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM, one write port and one read port on one clock.
// Read is registered (one-cycle latency), write-first on address collision, and the
// read data port floats to Z whenever re is low so it can share a read bus.
// Optional feature macro: DUAL_PORT_RAM_PARITY_EN (per-word even parity + rd_parity_err).
// The tri-state read data is a plain port so the Z driver stays at module level.
module dual_port_ram #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_port_ram_if.slave        bus,
  output wire  [DATA_WIDTH-1:0] read
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  collide_c;

  assign collide_c = bus.we && bus.re && (bus.WAdr == bus.RAdr);

  // Next read register: bypass write data on collision, hold when re is low.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.re) begin
      rdata_d = collide_c ? bus.write : mem_q[bus.RAdr];
    end
  end

  // Storage array and read register; reset clears every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (bus.we) begin
        mem_q[bus.WAdr] <= bus.write;
      end
      rdata_q <= rdata_d;
    end
  end

  // Read data driver follows re combinationally.
  assign read = bus.re ? rdata_q : {DATA_WIDTH{1'bz}};

`ifdef DUAL_PORT_RAM_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             perr_q;
  logic             perr_d;

  // Parity check on read update; a collision bypass takes parity from write, so no error.
  always_comb begin
    perr_d = perr_q;
    if (bus.re) begin
      perr_d = collide_c ? 1'b0 : ((^mem_q[bus.RAdr]) != par_q[bus.RAdr]);
    end
  end

  // Parity bit storage and registered error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      if (bus.we) begin
        par_q[bus.WAdr] <= ^bus.write;
      end
      perr_q <= perr_d;
    end
  end

  assign bus.rd_parity_err = perr_q;
`else
  assign bus.rd_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram.
module tb_dual_port_ram;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  wire  [DW-1:0] read;

  int n_pass;
  int n_total;

  dual_port_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .read (read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] exp);
    n_total++;
    assert (read === exp) n_pass++;
    else $error("FAIL %s: read=%h expected=%h", tag, read, exp);
  endtask

  task automatic chk_err(input string tag, input logic exp);
    n_total++;
    assert (bus.rd_parity_err === exp) n_pass++;
    else $error("FAIL %s: rd_parity_err=%b expected=%b", tag, bus.rd_parity_err, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst       = 1'b1;
    bus.we    = 1'b0;
    bus.WAdr  = '0;
    bus.write = '0;
    bus.re    = 1'b0;
    bus.RAdr  = '0;
    tick();
    rst = 1'b0;

    // Reset state: output floating, no parity error
    n_total++;
    assert (read === 8'hzz) n_pass++;
    else $error("FAIL reset_z: read=%h expected=zz", read);
    chk_err("reset_err", 1'b0);

    // 1. Read cleared memory at both ends of the address range
    bus.re = 1'b1; bus.RAdr = 5'h00;
    tick();
    chk_data("rd_addr00", 8'h00);
    bus.RAdr = 5'h1F;
    tick();
    chk_data("rd_addr1f", 8'h00);

    // 2. Concurrent write/read at different addresses
    bus.we = 1'b1; bus.WAdr = 5'd0; bus.write = 8'h01;
    tick();
    bus.WAdr = 5'd1; bus.write = 8'h02; bus.RAdr = 5'd0;
    tick();
    chk_data("wr_rd_addr0", 8'h01);
    bus.we = 1'b0; bus.RAdr = 5'd1;
    tick();
    chk_data("rd_addr1", 8'h02);

    // 3. Output driver follows re without a clock edge
    bus.re = 1'b0;
    #1;
    n_total++;
    assert (read === 8'hzz) n_pass++;
    else $error("FAIL re_low_z: read=%h expected=zz", read);
    bus.re = 1'b1;
    #1;
    chk_data("re_high_held", 8'h02);

    // 4. Blocked write
    bus.we = 1'b0; bus.WAdr = 5'd0; bus.write = 8'h03; bus.RAdr = 5'd0;
    tick();
    chk_data("we_low_blocked", 8'h01);

    // 5. Overwrite then collision (write-first)
    bus.we = 1'b1; bus.WAdr = 5'd0; bus.write = 8'h0F; bus.RAdr = 5'd1;
    tick();
    bus.we = 1'b0; bus.RAdr = 5'd0;
    tick();
    chk_data("overwrite", 8'h0F);
    bus.we = 1'b1; bus.WAdr = 5'd1; bus.RAdr = 5'd1; bus.write = 8'h0C;
    tick();
    chk_data("collision", 8'h0C);
    chk_err("collision_err", 1'b0);
    bus.we = 1'b0; bus.RAdr = 5'd0;
    tick();
    chk_data("after_coll_a0", 8'h0F);
    bus.RAdr = 5'd1;
    tick();
    chk_data("after_coll_a1", 8'h0C);

    // Read register holds while re is low, even as RAdr changes
    bus.re = 1'b0; bus.RAdr = 5'd0;
    tick();
    bus.re = 1'b1;
    #1;
    chk_data("hold_re_low", 8'h0C);

    // Reset clears memory and read register; a write during reset is ignored
    rst = 1'b1; bus.we = 1'b1; bus.WAdr = 5'd2; bus.write = 8'h55; bus.RAdr = 5'd0;
    tick();
    chk_data("reset_rdreg", 8'h00);
    rst = 1'b0; bus.we = 1'b0; bus.RAdr = 5'd1;
    tick();
    chk_data("reset_mem1", 8'h00);
    bus.RAdr = 5'd2;
    tick();
    chk_data("reset_blocks_wr", 8'h00);

    // 6. Parity: write 0xA5 to addr 3
    bus.we = 1'b1; bus.WAdr = 5'd3; bus.write = 8'hA5; bus.RAdr = 5'd0;
    tick();
    bus.we = 1'b0; bus.RAdr = 5'd3;
    tick();
    chk_data("par_clean_rd", 8'hA5);
    chk_err("par_clean_err", 1'b0);
`ifdef DUAL_PORT_RAM_PARITY_EN
    dut.par_q[3] = ~dut.par_q[3];
    tick();
    chk_data("par_bad_rd", 8'hA5);
    chk_err("par_bad_err", 1'b1);
    // Collision on the corrupted word takes parity from write data
    bus.we = 1'b1; bus.WAdr = 5'd3; bus.write = 8'h5A;
    tick();
    chk_data("par_coll_rd", 8'h5A);
    chk_err("par_coll_err", 1'b0);
`else
    tick();
    chk_data("par_off_rd", 8'hA5);
    chk_err("par_off_err", 1'b0);
`endif
    bus.we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
